// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage for the RV64 datapath. Takes the ALU result as the
//   effective address, performs a load or store on a 32-bit word-addressed
//   data-memory bus with a req/ack handshake (doublewords take two beats),
//   and returns sign/zero-extended load data or a store completion, together
//   with an error code.
//
// Ports
//   clk, rst_n           : clock (rising edge), synchronous active-low reset
//   req_valid/req_ready  : core request handshake
//   req_we, req_funct3   : 1=store/0=load, RV64 load/store funct3
//   req_addr, req_wdata  : effective address, store data (rs2)
//   resp_valid           : one-cycle completion pulse
//   resp_rdata, resp_err : extended load data, 00 ok/01 misaligned/
//                          10 illegal funct3/11 timeout
//   mem_req, mem_we      : bus request / write strobe
//   mem_addr, mem_be     : word-aligned byte address, byte enables
//   mem_wdata            : lane-aligned write data
//   mem_ack, mem_rdata   : beat complete, read word (valid with ack)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        hi_q, hi_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               illegal;
    logic               misaligned;
    logic               is_double;
    logic               timeout_hit;
    logic [ADDR_W-1:0]  base_addr;
    logic [63:0]        load_data;

    // Upper address bits beyond the bus width are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[63:ADDR_W];

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // Loads reserve only 111; stores reserve every code with bit 2 set.
    assign illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);

    // Access size is encoded in funct3[1:0] for both loads and stores.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign is_double   = (funct3_q[1:0] == 2'b11);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign base_addr   = {addr_q[ADDR_W-1:2], 2'b00};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // ---------------- next-state / datapath next ----------------
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDR_W-1:0];
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    // Illegal code wins over misalignment; neither touches memory.
                    if (illegal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = RESP;
                    end else if (misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (mem_ack) begin
                    if (state_q == BEAT0) begin
                        lo_d = mem_rdata;
                    end else begin
                        hi_d = mem_rdata;
                    end
                    cnt_d   = '0;
                    state_d = (state_q == BEAT0 && is_double) ? BEAT1 : RESP;
                end else if (timeout_hit) begin
                    // Abandon the transfer, skipping any remaining beat.
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- load data extraction ----------------
    always_comb begin
        load_data = '0;
        case (funct3_q)
            3'b000: load_data = {{56{lo_q[{addr_q[1:0], 3'b000} + 7]}},
                                 lo_q[{addr_q[1:0], 3'b000} +: 8]};
            3'b100: load_data = {56'd0, lo_q[{addr_q[1:0], 3'b000} +: 8]};
            3'b001: load_data = {{48{lo_q[{addr_q[1], 4'b0000} + 15]}},
                                 lo_q[{addr_q[1], 4'b0000} +: 16]};
            3'b101: load_data = {48'd0, lo_q[{addr_q[1], 4'b0000} +: 16]};
            3'b010: load_data = {{32{lo_q[31]}}, lo_q};
            3'b110: load_data = {32'd0, lo_q};
            3'b011: load_data = {hi_q, lo_q};
            default: load_data = '0;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 64'd0;
        resp_err   = ERR_OK;
        case (state_q)
            BEAT0, BEAT1: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                // Second beat wraps naturally within the ADDR_W-bit space.
                mem_addr = (state_q == BEAT1) ? base_addr + ADDR_W'(4) : base_addr;
                mem_be   = 4'b1111;
                if (we_q) begin
                    if (state_q == BEAT1) begin
                        mem_wdata = wdata_q[63:32];
                    end else begin
                        case (funct3_q[1:0])
                            2'b00: begin
                                mem_be    = 4'b0001 << addr_q[1:0];
                                mem_wdata = {4{wdata_q[7:0]}};
                            end
                            2'b01: begin
                                mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                                mem_wdata = {2{wdata_q[15:0]}};
                            end
                            default: begin
                                mem_wdata = wdata_q[31:0];
                            end
                        endcase
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q == ERR_OK && !we_q) ? load_data : 64'd0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Per-transaction observations, filled by do_op.
    int          c_req_first, n_req, c_resp, n_resp, n_beat;
    logic [63:0] r_rdata;
    logic [1:0]  r_err;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_be   [2];
    logic        b_we   [2];
    logic [31:0] rd_words[2];
    logic        req_tr  [32];
    logic        ready_tr[32];
    logic        ready_at_accept;

    // Issue one request and act as the memory for ncyc cycles after accept.
    // Beats get acked after ack_delay waiting cycles, at most ack_limit beats.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int ack_delay, input int ack_limit,
                         input int rst_at, input int ncyc);
        int wait_cnt;
        int acked;
        wait_cnt = 0; acked = 0;
        c_req_first = -1; n_req = 0; c_resp = -1; n_resp = 0; n_beat = 0;
        r_rdata = '0; r_err = '0;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = '0; b_wdata[i] = '0; b_be[i] = '0; b_we[i] = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            req_tr[i] = 1'b0; ready_tr[i] = 1'b0;
        end
        @(negedge clk);
        ready_at_accept = req_ready;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            req_tr[c]   = mem_req;
            ready_tr[c] = req_ready;
            if (resp_valid) begin
                n_resp++;
                if (c_resp < 0) begin
                    c_resp = c; r_rdata = resp_rdata; r_err = resp_err;
                end
            end
            if (mem_req) begin
                if (c_req_first < 0) c_req_first = c;
                n_req++;
                if (wait_cnt == 0) begin
                    if (n_beat < 2) begin
                        b_addr[n_beat] = mem_addr; b_wdata[n_beat] = mem_wdata;
                        b_be[n_beat] = mem_be; b_we[n_beat] = mem_we;
                    end
                    n_beat++;
                end
                if (acked < ack_limit && wait_cnt == ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = rd_words[acked % 2];
                    acked++; wait_cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = '0; wait_cnt++;
                end
            end else begin
                mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
            end
            if (c == rst_at) rst_n = 1'b0;
            else if (c == rst_at + 1) rst_n = 1'b1;
        end
        mem_ack = 1'b0;
        $display("txn we=%0b f3=%03b addr=%h wdata=%h -> req@%0d beats=%0d resp@%0d n_resp=%0d rdata=%h err=%02b",
                 we, f3, addr, wdata, c_req_first, n_beat, c_resp, n_resp, r_rdata, r_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_cmp++;
        if ({mem_req, mem_we, resp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {mem_req, mem_we, resp_valid});
        end
        n_cmp++;
        if ({resp_rdata, resp_err, mem_addr, mem_be, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: rdata=%h err=%b addr=%h be=%b wdata=%h expected all 0",
                               resp_rdata, resp_err, mem_addr, mem_be, mem_wdata);
        end
        $display("txn reset released");
    endtask

    task automatic test_lw_lwu();
        rd_words[0] = 32'h8000_0001; rd_words[1] = '0;
        do_op(1'b0, 3'b010, 64'h100, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (ready_at_accept !== 1'b1) begin n_fail++; $display("FAIL lw_ready: got %b expected 1", ready_at_accept); end
        n_cmp++;
        if (c_req_first !== 1 || ready_tr[1] !== 1'b0) begin
            n_fail++; $display("FAIL lw_req_cycle: got %0d ready=%b expected 1 ready=0", c_req_first, ready_tr[1]);
        end
        n_cmp++;
        if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1111 || b_we[0] !== 1'b0) begin
            n_fail++; $display("FAIL lw_bus: addr=%h be=%b we=%b expected 00000100 1111 0", b_addr[0], b_be[0], b_we[0]);
        end
        n_cmp++;
        if (c_resp !== 2 || n_resp !== 1) begin
            n_fail++; $display("FAIL lw_resp_timing: got cycle %0d count %0d expected 2 1", c_resp, n_resp);
        end
        n_cmp++;
        if (r_rdata !== 64'hFFFF_FFFF_8000_0001 || r_err !== 2'b00) begin
            n_fail++; $display("FAIL lw_data: got %h err %b expected ffffffff80000001 00", r_rdata, r_err);
        end
        do_op(1'b0, 3'b110, 64'h100, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (r_rdata !== 64'h0000_0000_8000_0001 || r_err !== 2'b00 || c_resp !== 2) begin
            n_fail++; $display("FAIL lwu_data: got %h err %b cycle %0d expected 0000000080000001 00 2", r_rdata, r_err, c_resp);
        end
    endtask

    task automatic test_lb_lhu();
        rd_words[0] = 32'h8000_0000;
        do_op(1'b0, 3'b000, 64'h103, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (r_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || b_addr[0] !== 32'h100) begin
            n_fail++; $display("FAIL lb_data: got %h addr %h expected ffffffffffffff80 00000100", r_rdata, b_addr[0]);
        end
        rd_words[0] = 32'hBEEF_0000;
        do_op(1'b0, 3'b101, 64'h102, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (r_rdata !== 64'h0000_0000_0000_BEEF || r_err !== 2'b00) begin
            n_fail++; $display("FAIL lhu_data: got %h err %b expected 000000000000beef 00", r_rdata, r_err);
        end
    endtask

    task automatic test_sd_delayed();
        do_op(1'b1, 3'b011, 64'h200, 64'h1122_3344_5566_7788, 2, 2, 100, 12);
        n_cmp++;
        if (n_beat !== 2 || b_addr[0] !== 32'h200 || b_wdata[0] !== 32'h5566_7788 || b_be[0] !== 4'b1111 || b_we[0] !== 1'b1) begin
            n_fail++; $display("FAIL sd_beat0: beats=%0d addr=%h wdata=%h be=%b we=%b expected 2 00000200 55667788 1111 1",
                               n_beat, b_addr[0], b_wdata[0], b_be[0], b_we[0]);
        end
        n_cmp++;
        if (b_addr[1] !== 32'h204 || b_wdata[1] !== 32'h1122_3344 || b_be[1] !== 4'b1111 || b_we[1] !== 1'b1) begin
            n_fail++; $display("FAIL sd_beat1: addr=%h wdata=%h be=%b we=%b expected 00000204 11223344 1111 1",
                               b_addr[1], b_wdata[1], b_be[1], b_we[1]);
        end
        // 3 req cycles per beat with no gap between beats; response right after.
        n_cmp++;
        if (n_req !== 6 || c_resp !== 7 || n_resp !== 1 || r_err !== 2'b00 || r_rdata !== 64'd0) begin
            n_fail++; $display("FAIL sd_resp: req_cycles=%0d cycle=%0d count=%0d err=%b rdata=%h expected 6 7 1 00 0",
                               n_req, c_resp, n_resp, r_err, r_rdata);
        end
    endtask

    task automatic test_store_lanes_errors();
        do_op(1'b1, 3'b001, 64'h6, 64'hABCD, 0, 2, 100, 8);
        n_cmp++;
        if (b_be[0] !== 4'b1100 || b_wdata[0] !== 32'hABCD_ABCD || b_addr[0] !== 32'h4 || r_err !== 2'b00) begin
            n_fail++; $display("FAIL sh_lanes: be=%b wdata=%h addr=%h err=%b expected 1100 abcdabcd 00000004 00",
                               b_be[0], b_wdata[0], b_addr[0], r_err);
        end
        do_op(1'b1, 3'b000, 64'h101, 64'h5A, 0, 2, 100, 8);
        n_cmp++;
        if (b_be[0] !== 4'b0010 || b_wdata[0] !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL sb_lanes: be=%b wdata=%h expected 0010 5a5a5a5a", b_be[0], b_wdata[0]);
        end
        do_op(1'b1, 3'b010, 64'h102, 64'h1234, 0, 2, 100, 6);
        n_cmp++;
        if (n_req !== 0 || c_resp !== 1 || n_resp !== 1 || r_err !== 2'b01) begin
            n_fail++; $display("FAIL sw_misaligned: req_cycles=%0d cycle=%0d count=%0d err=%b expected 0 1 1 01",
                               n_req, c_resp, n_resp, r_err);
        end
        do_op(1'b1, 3'b100, 64'h100, 64'h1234, 0, 2, 100, 6);
        n_cmp++;
        if (n_req !== 0 || c_resp !== 1 || r_err !== 2'b10 || r_rdata !== 64'd0) begin
            n_fail++; $display("FAIL store_illegal: req_cycles=%0d cycle=%0d err=%b rdata=%h expected 0 1 10 0",
                               n_req, c_resp, r_err, r_rdata);
        end
        do_op(1'b0, 3'b111, 64'h100, 64'h0, 0, 2, 100, 6);
        n_cmp++;
        if (n_req !== 0 || r_err !== 2'b10) begin
            n_fail++; $display("FAIL load_illegal: req_cycles=%0d err=%b expected 0 10", n_req, r_err);
        end
    endtask

    task automatic test_ld_top_and_timeout();
        rd_words[0] = 32'h89AB_CDEF; rd_words[1] = 32'h0123_4567;
        do_op(1'b0, 3'b011, 64'hFFFF_FFF8, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (b_addr[0] !== 32'hFFFF_FFF8 || b_addr[1] !== 32'hFFFF_FFFC || n_req !== 2) begin
            n_fail++; $display("FAIL ld_addrs: %h %h req_cycles=%0d expected fffffff8 fffffffc 2", b_addr[0], b_addr[1], n_req);
        end
        n_cmp++;
        if (r_rdata !== 64'h0123_4567_89AB_CDEF || c_resp !== 3 || r_err !== 2'b00) begin
            n_fail++; $display("FAIL ld_data: got %h cycle %0d err %b expected 0123456789abcdef 3 00", r_rdata, c_resp, r_err);
        end
        do_op(1'b0, 3'b011, 64'h400, 64'h0, 0, 0, 100, 24);
        n_cmp++;
        if (n_req !== 16 || n_beat !== 1 || c_resp !== 17 || n_resp !== 1) begin
            n_fail++; $display("FAIL ld_timeout_timing: req_cycles=%0d beats=%0d cycle=%0d count=%0d expected 16 1 17 1",
                               n_req, n_beat, c_resp, n_resp);
        end
        n_cmp++;
        if (r_err !== 2'b11 || r_rdata !== 64'd0) begin
            n_fail++; $display("FAIL ld_timeout_resp: err=%b rdata=%h expected 11 0", r_err, r_rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        rd_words[0] = 32'h1111_1111; rd_words[1] = 32'h2222_2222;
        // Beat0 acked at cycle 1, beat1 hangs; reset asserted during cycle 2.
        do_op(1'b0, 3'b011, 64'h300, 64'h0, 0, 1, 2, 10);
        n_cmp++;
        if (req_tr[2] !== 1'b1 || b_addr[1] !== 32'h304) begin
            n_fail++; $display("FAIL rst_beat1: req=%b addr=%h expected 1 00000304", req_tr[2], b_addr[1]);
        end
        n_cmp++;
        if (req_tr[3] !== 1'b0 || ready_tr[3] !== 1'b0 || ready_tr[4] !== 1'b1) begin
            n_fail++; $display("FAIL rst_abort: req=%b ready=%b ready_after=%b expected 0 0 1", req_tr[3], ready_tr[3], ready_tr[4]);
        end
        n_cmp++;
        if (n_resp !== 0) begin n_fail++; $display("FAIL rst_no_resp: got %0d expected 0", n_resp); end
        rd_words[0] = 32'h7FFF_FFFF;
        do_op(1'b0, 3'b010, 64'h100, 64'h0, 0, 2, 100, 8);
        n_cmp++;
        if (r_rdata !== 64'h0000_0000_7FFF_FFFF || c_resp !== 2 || n_resp !== 1 || r_err !== 2'b00) begin
            n_fail++; $display("FAIL rst_recover_lw: got %h cycle %0d count %0d err %b expected 000000007fffffff 2 1 00",
                               r_rdata, c_resp, n_resp, r_err);
        end
    endtask

    initial begin
        test_reset();
        test_lw_lwu();
        test_lb_lhu();
        test_sd_delayed();
        test_store_lanes_errors();
        test_ld_top_and_timeout();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the 64-bit ALU in the RV64 datapath.
- Takes the ALU result as the effective address, plus the load/store funct3 and store data.
- Performs the access on a 32-bit word-addressed data-memory bus with a req/ack handshake. Doublewords take two beats.
- Returns sign- or zero-extended 64-bit load data, or a completion for stores, with an error code.

Parameters:
- ADDR_W, 32, width of mem_addr (byte address, low 2 bits always 0).
- TIMEOUT, 16, max cycles a beat waits for mem_ack before aborting (≥1).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; store: 000 SB, 001 SH, 010 SW, 011 SD
- req_addr  in  64  effective address (ALU result)
- req_wdata  in  64  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data (0 for stores/errors)
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_be  out  4  byte enables (writes; 1111 on reads)
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  beat complete; mem_rdata valid same cycle
- mem_rdata  in  32  read word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state IDLE; mem_req, mem_we, resp_valid = 0; resp_rdata, resp_err, mem_addr, mem_be, mem_wdata, timeout counter = 0.
- Reset mid-transaction: on the reset edge, mem_req drops, the pending op is discarded and no resp_valid is produced.
- req_ready = (state==IDLE) && rst_n. Accept occurs when req_valid && req_ready. The unit registers funct3, we, addr and wdata on accept.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE, on accept:
  - Illegal code (load 111; store 1xx): go to RESP, err=10.
  - Misaligned access: go to RESP, err=01. Alignment rules: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - Otherwise: go to BEAT0. No memory access occurs on either error path.
- BEAT0:
  - mem_req=1, mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - All mem_* outputs stay stable while mem_req=1.
  - mem_ack may arrive in the first req cycle.
  - On ack: capture mem_rdata as lo. Then go to BEAT1 if LD/SD, else to RESP.
- BEAT1:
  - mem_addr = BEAT0 address + 4, modulo 2^ADDR_W (wraps).
  - On ack: capture hi, go to RESP.
  - mem_req drops for zero cycles between beats: it stays high while the address changes.
- Timeout:
  - Counter resets at each beat start and increments each req cycle without ack.
  - When it reaches TIMEOUT without ack: drop mem_req, go to RESP, err=11, rdata=0. Any remaining beat is skipped.
  - A late mem_ack in IDLE/RESP is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during RESP. Next accept is possible the cycle after RESP.
- Latency (ack in first req cycle): accept at T, mem_req at T+1, resp_valid at T+2 for single-beat ops; T+3 for D. Error paths give resp_valid at T+1.
- Load data extraction from lo word:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: half lane addr[1].
  - LW/LWU: full word.
  - LB/LH/LW sign-extend to 64; LBU/LHU/LWU zero-extend.
  - LD = {hi,lo}.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be = addr[1]?1100:0011, wdata = half replicated x2.
  - SW: be 1111, wdata[31:0].
  - SD: beat0 wdata[31:0], beat1 wdata[63:32], be 1111 both.
- Reads: mem_we=0, be=1111.
- Stores: resp_rdata=0.
- req_valid while busy is ignored (not queued).

Test Plan:
- LW at addr 0x100, mem_rdata=0x8000_0001, ack first cycle -> mem_addr=0x100, be=1111; resp_valid at T+2, rdata=0xFFFF_FFFF_8000_0001, err=00. Repeat as LWU -> 0x0000_0000_8000_0001.
- LB addr 0x103, rdata word 0x80_00_00_00 -> rdata=0xFFFF_FFFF_FFFF_FF80. LHU addr 0x102, word 0xBEEF_0000 -> 0x0000_0000_0000_BEEF.
- SD addr 0x200, wdata 0x1122_3344_5566_7788, ack delayed 2 cycles per beat -> beat0 addr 0x200 wdata 0x5566_7788; beat1 addr 0x204 wdata 0x1122_3344; resp_valid once, err=00.
- SH addr 0x0000_0006, wdata 0xABCD -> be=1100, mem_wdata=0xABCD_ABCD. SW addr 0x102 -> no mem_req, resp_valid at T+1, err=01. Store funct3 100 -> err=10.
- LD addr 0xFFFF_FFF8 (ADDR_W=32) -> beat addrs 0xFFFF_FFF8, 0xFFFF_FFFC. LD with no mem_ack, TIMEOUT=16 -> mem_req held 16 cycles, then resp err=11, rdata=0.
- rst_n low during BEAT1 of an LD -> next cycle mem_req=0, state IDLE, no resp_valid. After release, req_ready=1 and a new LW completes normally.
